// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the 2:1 memory arbiter.
// The ERR states exist only when ARB_TIMEOUT_EN is defined.
package mem_arb_pkg;

`ifdef ARB_TIMEOUT_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BUSY0 = 3'd1,
      ST_BUSY1 = 3'd2,
      ST_ERR0  = 3'd3,
      ST_ERR1  = 3'd4
   } arb_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BUSY0 = 3'd1,
      ST_BUSY1 = 3'd2
   } arb_state_t;
`endif

   localparam logic [31:0] DEF_ERR_RDATA = 32'hDEADBEEF;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin pick: when both request, the one not served last wins.
module arb_rr2 (
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last,
   output logic o_vld,
   output logic o_pick1
);

   // i_last = 1 means requester 1 was served most recently
   assign o_vld   = i_req0 | i_req1;
   assign o_pick1 = i_req1 & (~i_req0 | ~i_last);

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Two picorv32-style native-bus masters sharing one memory port, round-robin.
// Define ARB_TIMEOUT_EN to add a slave-ready timeout with ERR0/ERR1 states.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// BUSY0 | m0 owns slave port, waiting for s_ready
// BUSY1 | m1 owns slave port, waiting for s_ready
// ERR0  | m0 timed out; one-cycle error response
// ERR1  | m1 timed out; one-cycle error response
module mem_arbiter_2to1
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant
);

   arb_state_t  r_state;
   arb_state_t  w_state_nxt;
   logic        r_last;
   logic        r_s_valid;
   logic        r_s_instr;
   logic [31:0] r_s_addr;
   logic [31:0] r_s_wdata;
   logic [3:0]  r_s_wstrb;
   logic        w_pick_vld;
   logic        w_pick1;
   logic        w_busy;
   logic        w_ack0;
   logic        w_ack1;
   logic        w_err0;
   logic        w_err1;

   arb_rr2 u_rr (
      .i_req0  (m0_valid),
      .i_req1  (m1_valid),
      .i_last  (r_last),
      .o_vld   (w_pick_vld),
      .o_pick1 (w_pick1)
   );

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   logic [15:0] r_to_cnt;
   logic        w_to_hit;

   // counts stalled BUSY cycles; the TIMEOUT-th stall moves to ERR
   assign w_to_hit = (r_to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_to_cnt <= '0;
      else if (w_busy && !s_ready)
         r_to_cnt <= r_to_cnt + 16'd1;
      else
         r_to_cnt <= '0;
   end

   assign w_err0 = (r_state == ST_ERR0);
   assign w_err1 = (r_state == ST_ERR1);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT;
   assign w_err0 = 1'b0;
   assign w_err1 = 1'b0;
`endif

   assign w_busy = (r_state == ST_BUSY0) || (r_state == ST_BUSY1);
   assign w_ack0 = (r_state == ST_BUSY0) && s_ready;
   assign w_ack1 = (r_state == ST_BUSY1) && s_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_pick_vld)
               w_state_nxt = w_pick1 ? ST_BUSY1 : ST_BUSY0;
         end
         ST_BUSY0: begin
            if (s_ready)
               w_state_nxt = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
            else if (w_to_hit)
               w_state_nxt = ST_ERR0;
`endif
         end
         ST_BUSY1: begin
            if (s_ready)
               w_state_nxt = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
            else if (w_to_hit)
               w_state_nxt = ST_ERR1;
`endif
         end
`ifdef ARB_TIMEOUT_EN
         ST_ERR0, ST_ERR1: w_state_nxt = ST_IDLE;
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // slave request is captured at the grant edge and frozen until the owner leaves BUSY
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_last    <= 1'b1;
         r_s_valid <= 1'b0;
         r_s_instr <= 1'b0;
         r_s_addr  <= '0;
         r_s_wdata <= '0;
         r_s_wstrb <= '0;
      end else begin
         if ((r_state == ST_IDLE) && w_pick_vld) begin
            r_s_valid <= 1'b1;
            r_s_instr <= w_pick1 ? m1_instr : m0_instr;
            r_s_addr  <= w_pick1 ? m1_addr  : m0_addr;
            r_s_wdata <= w_pick1 ? m1_wdata : m0_wdata;
            r_s_wstrb <= w_pick1 ? m1_wstrb : m0_wstrb;
         end else if (w_busy && (w_state_nxt != r_state)) begin
            r_s_valid <= 1'b0;
         end

         if (m0_ready)
            r_last <= 1'b0;
         else if (m1_ready)
            r_last <= 1'b1;
      end
   end

   assign s_valid = r_s_valid;
   assign s_instr = r_s_instr;
   assign s_addr  = r_s_addr;
   assign s_wdata = r_s_wdata;
   assign s_wstrb = r_s_wstrb;

   assign m0_ready = w_ack0 | w_err0;
   assign m1_ready = w_ack1 | w_err1;
   assign m0_rdata = w_ack0 ? s_rdata : (w_err0 ? ERR_RDATA : '0);
   assign m1_rdata = w_ack1 ? s_rdata : (w_err1 ? ERR_RDATA : '0);

   assign grant = ((r_state == ST_BUSY0) || w_err0) ? GRANT_M0 :
                  ((r_state == ST_BUSY1) || w_err1) ? GRANT_M1 : GRANT_NONE;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Scoreboard bench for mem_arbiter_2to1; timeout case runs only with ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_mem_arbiter_2to1;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_valid, m0_instr, m0_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_wstrb;
   logic        m1_valid, m1_instr, m1_ready;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        s_valid, s_instr, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;

   mem_arbiter_2to1 #(.TIMEOUT(16), .ERR_RDATA(32'hDEADBEEF)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      int          drop;
   } txn_t;

   txn_t q0[$];
   txn_t q1[$];
   txn_t sb[$];

   int checks = 0;
   int errors = 0;

   bit seen [2];
   bit busy [2];
   int drop_cd [2];

   int slv_lat = 1;
   bit slv_hold = 0;
   bit slv_idle_rdy = 0;
   int slv_wait = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] slv_data(input logic [31:0] a);
      if (a == 32'h10) return 32'h00A00113;
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic push_req(input bit id, input bit instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int drop, input bit err);
      txn_t t;
      t.id    = id;
      t.instr = instr;
      t.addr  = addr;
      t.wdata = wdata;
      t.wstrb = wstrb;
      t.drop  = drop;
      t.rdata = err ? 32'hDEADBEEF : slv_data(addr);
      if (id) q1.push_back(t);
      else    q0.push_back(t);
      sb.push_back(t);
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_svalid(input int budget, input string tag);
      int n = 0;
      while (!s_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_svalid"}, 32'(s_valid), 32'd1);
   endtask

   // slave model: responds slv_lat cycles after s_valid rises
   initial begin
      s_ready = 1'b0;
      s_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         s_ready = 1'b0;
         if (s_valid && !slv_hold) begin
            if (slv_wait >= slv_lat) begin
               s_ready   = 1'b1;
               s_rdata   = slv_data(s_addr);
               slv_wait  = 0;
            end else begin
               slv_wait++;
            end
         end else begin
            slv_wait = 0;
            if (!s_valid && slv_idle_rdy) begin
               s_ready = 1'b1;
               s_rdata = 32'h0BAD0BAD;
            end
         end
      end
   end

   // master drivers: hold a request until its ready is observed
   initial begin : drv
      txn_t t;
      m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
      m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
      forever begin
         @(posedge clk);
         #1;
         if (busy[0] && seen[0]) begin busy[0] = 0; seen[0] = 0; m0_valid = 0; end
         if (busy[0] && drop_cd[0] > 0) begin
            drop_cd[0]--;
            if (drop_cd[0] == 0) m0_valid = 0;
         end
         if (!busy[0] && q0.size() > 0) begin
            t = q0.pop_front();
            m0_instr = t.instr; m0_addr = t.addr; m0_wdata = t.wdata; m0_wstrb = t.wstrb;
            m0_valid = 1; busy[0] = 1; drop_cd[0] = t.drop;
         end
         if (busy[1] && seen[1]) begin busy[1] = 0; seen[1] = 0; m1_valid = 0; end
         if (busy[1] && drop_cd[1] > 0) begin
            drop_cd[1]--;
            if (drop_cd[1] == 0) m1_valid = 0;
         end
         if (!busy[1] && q1.size() > 0) begin
            t = q1.pop_front();
            m1_instr = t.instr; m1_addr = t.addr; m1_wdata = t.wdata; m1_wstrb = t.wstrb;
            m1_valid = 1; busy[1] = 1; drop_cd[1] = t.drop;
         end
      end
   end

   // monitor: slave-side fields against scoreboard head, completions pop it
   initial begin : mon
      txn_t e;
      bit   prev_done;
      prev_done = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            prev_done = 0;
         end else begin
            if (prev_done) chk("s_valid_gap", 32'(s_valid), 32'd0);
            prev_done = s_valid && s_ready;
            if (s_valid) begin
               if (sb.size() == 0) begin
                  chk("s_valid_unexpected", 32'(s_valid), 32'd0);
               end else begin
                  chk("s_addr",  s_addr, sb[0].addr);
                  chk("s_wdata", s_wdata, sb[0].wdata);
                  chk("s_wstrb", 32'(s_wstrb), 32'(sb[0].wstrb));
                  chk("s_instr", 32'(s_instr), 32'(sb[0].instr));
                  chk("s_grant", 32'(grant), sb[0].id ? 32'd2 : 32'd1);
               end
            end
            if (m0_ready) seen[0] = 1'b1;
            if (m1_ready) seen[1] = 1'b1;
            if (m0_ready || m1_ready) begin
               if (sb.size() == 0) begin
                  chk("spurious_ready", 32'({m1_ready, m0_ready}), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("ready_id", 32'({m1_ready, m0_ready}), e.id ? 32'd2 : 32'd1);
                  chk("rdata", e.id ? m1_rdata : m0_rdata, e.rdata);
                  chk("other_rdata", e.id ? m0_rdata : m1_rdata, 32'd0);
                  chk("grant", 32'(grant), e.id ? 32'd2 : 32'd1);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_valid", 32'(s_valid), 32'd0);
      chk("rst_grant",   32'(grant),   32'd0);
      chk("rst_ready",   32'({m1_ready, m0_ready}), 32'd0);
      chk("rst_s_addr",  s_addr, 32'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // m0 read of 0x10, slave answers after one cycle
      slv_lat = 1;
      push_req(0, 0, 32'h10, 32'h0, 4'h0, 0, 0);
      wait_drain(50, "t1");
      chk("t1_m1_quiet", 32'(seen[1]), 32'd0);

      // fresh reset, both masters streaming: expect 0,1,0,1,0,1
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      slv_lat = 2;
      for (int i = 0; i < 6; i++)
         push_req(i[0], i[1], 32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 4'(i), 0, 0);
      wait_drain(200, "t2");

      // m1 write
      slv_lat = 0;
      push_req(1, 0, 32'h20, 32'h12345678, 4'b0011, 0, 0);
      wait_drain(50, "t3");

      // m0 drops valid mid-transaction, must still complete
      slv_lat = 3;
      push_req(0, 1, 32'h3C, 32'h0, 4'h0, 2, 0);
      wait_drain(50, "t4");

      // s_ready while idle is ignored
      slv_idle_rdy = 1;
      repeat (5) @(negedge clk);
      slv_idle_rdy = 0;
      chk("t6_no_ready", 32'({seen[1], seen[0]}), 32'd0);
      chk("t6_grant", 32'(grant), 32'd0);
      @(negedge clk);

      // reset while m0 is in BUSY0
      slv_hold = 1;
      push_req(0, 1, 32'h40, 32'h55AA55AA, 4'hF, 0, 0);
      wait_svalid(20, "t7");
      chk("t7_grant", 32'(grant), 32'd1);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("t7_s_valid", 32'(s_valid), 32'd0);
      chk("t7_s_addr",  s_addr, 32'd0);
      chk("t7_s_wdata", s_wdata, 32'd0);
      chk("t7_s_wstrb", 32'(s_wstrb), 32'd0);
      chk("t7_s_instr", 32'(s_instr), 32'd0);
      chk("t7_grant0",  32'(grant), 32'd0);
      sb.delete();
      q0.delete();
      busy[0] = 0;
      seen[0] = 0;
      m0_valid = 0;
      slv_hold = 0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (20) @(negedge clk);
      chk("t7_no_ready", 32'(seen[0]), 32'd0);

      // pointer must be back at m1-served-last: m0 wins a tie
      slv_lat = 1;
      push_req(0, 0, 32'h80, 32'h0, 4'h0, 0, 0);
      push_req(1, 1, 32'h84, 32'h0, 4'h0, 0, 0);
      wait_drain(100, "t8");

`ifdef ARB_TIMEOUT_EN
      // slave never answers: 16 cycles of s_valid then error response
      slv_hold = 1;
      push_req(0, 0, 32'hC0, 32'h0, 4'h0, 0, 1);
      wait_svalid(20, "t9");
      slv_idle_rdy = 1;
      n = 0;
      while (s_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("t9_svalid_cycles", 32'(n), 32'd16);
      wait_drain(20, "t9");
      slv_hold = 0;
      slv_idle_rdy = 0;
      repeat (3) @(negedge clk);
`endif

      chk("end_sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
